// File: rtl/score_counter_bcd.sv
// -----------------------------------------------------------------------------
// score_counter_bcd
//
// Multi-digit BCD score counter for the game datapath. It counts increment
// requests from the game FSM, either wraps or saturates at the all-nines
// maximum, keeps a session high score, and drives active-low 7-segment
// patterns for the HEX displays, with optional leading-zero blanking.
//
// Parameters
//   DIGITS    number of BCD digits (1..6); max score is 10^DIGITS-1
//   WRAP      1: wrap to zero past max, 0: saturate at max
//   BLANK_LZ  1: blank leading zero digits (digit 0 is never blanked)
//
// Ports
//   clk         system clock, all state updates on the rising edge
//   reset       asynchronous, active-high; clears all state immediately
//   active      game running; low forces the score to zero
//   clear       synchronous clear of score, overflow and new_high
//   clear_high  synchronous clear of high_score
//   increment   add one to the score (counts once per cycle it is high)
//   score_bcd   registered score, digit 0 at bits [3:0]
//   display     active-low segments {g..a} per digit, digit 0 at bits [6:0]
//   overflow    registered one-cycle pulse per increment taken at max
//   high_score  registered best score since reset or clear_high
//   new_high    sticky: the current game has beaten the stored high score
// -----------------------------------------------------------------------------
module score_counter_bcd #(
  parameter int DIGITS   = 3,
  parameter bit WRAP     = 1'b1,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  active,
  input  logic                  clear,
  input  logic                  clear_high,
  input  logic                  increment,
  output logic [4*DIGITS-1:0]   score_bcd,
  output logic [7*DIGITS-1:0]   display,
  output logic                  overflow,
  output logic [4*DIGITS-1:0]   high_score,
  output logic                  new_high
);

  localparam int SCORE_W = 4 * DIGITS;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  // Active-low {g,f,e,d,c,b,a} pattern for one BCD digit. Non-BCD codes
  // cannot be produced by the counter; they show a dash so a corrupted
  // register is visible instead of showing a plausible digit.
  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = SEG_DASH;
    endcase
    return seg;
  endfunction

  // Unsigned BCD magnitude compare, most significant digit first. The first
  // digit position that differs decides the result.
  function automatic logic bcd_greater(input logic [SCORE_W-1:0] a,
                                       input logic [SCORE_W-1:0] b);
    logic gt;
    logic decided;
    gt      = 1'b0;
    decided = 1'b0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      if (!decided) begin
        if (a[4*k +: 4] > b[4*k +: 4]) begin
          gt      = 1'b1;
          decided = 1'b1;
        end else if (a[4*k +: 4] < b[4*k +: 4]) begin
          decided = 1'b1;
        end
      end
    end
    return gt;
  endfunction

  // ---------------------------------------------------------------------------
  // Ripple BCD +1 of the current score. carry[k] is high when every digit
  // below k is 9, i.e. digit k would step if an increment is taken. A carry
  // out of the top digit means the score is at its maximum; the incremented
  // value is then all zeros, which is exactly the wrap result.
  // ---------------------------------------------------------------------------
  logic [DIGITS:0]  carry;
  logic [SCORE_W-1:0] score_inc;
  logic             at_max;

  always_comb begin
    logic [3:0] digit;
    carry     = '0;
    carry[0]  = 1'b1;
    score_inc = score_bcd;
    digit     = 4'd0;
    for (int k = 0; k < DIGITS; k++) begin
      digit = score_bcd[4*k +: 4];
      if (carry[k]) begin
        if (digit == 4'd9) begin
          score_inc[4*k +: 4] = 4'd0;
          carry[k+1]          = 1'b1;
        end else begin
          score_inc[4*k +: 4] = digit + 4'd1;
        end
      end
    end
  end

  assign at_max = carry[DIGITS];

  // ---------------------------------------------------------------------------
  // Score and overflow register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      score_bcd <= '0;
      overflow  <= 1'b0;
    end else if (clear || !active) begin
      score_bcd <= '0;
      overflow  <= 1'b0;
    end else if (increment) begin
      // In saturate mode the score simply holds at max.
      if (WRAP || !at_max) begin
        score_bcd <= score_inc;
      end
      overflow <= at_max;
    end else begin
      overflow <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // High-score register. The compare looks at the registered score, so the
  // high score trails the score by one cycle. A cycle with clear_high only
  // zeroes the register; the compare picks up again on the following cycle.
  // ---------------------------------------------------------------------------
  logic beats_high;
  logic capture;

  assign beats_high = bcd_greater(score_bcd, high_score);
  assign capture    = active && !clear && !clear_high && beats_high;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      high_score <= '0;
    end else if (clear_high) begin
      high_score <= '0;
    end else if (capture) begin
      high_score <= score_bcd;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      new_high <= 1'b0;
    end else if (clear || !active) begin
      new_high <= 1'b0;
    end else if (capture) begin
      new_high <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Display decode with leading-zero blanking. zero_from[k] is high when
  // digit k and every digit above it are zero; such digits above digit 0
  // are blanked so a score of 7 reads "  7" rather than "007".
  // ---------------------------------------------------------------------------
  logic [DIGITS:0] zero_from;

  always_comb begin
    logic [3:0] digit;
    logic       blank;
    zero_from         = '0;
    zero_from[DIGITS] = 1'b1;
    display           = '0;
    digit             = 4'd0;
    blank             = 1'b0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      digit        = score_bcd[4*k +: 4];
      zero_from[k] = zero_from[k+1] && (digit == 4'd0);
      blank        = BLANK_LZ && (k > 0) && zero_from[k];
      display[7*k +: 7] = blank ? SEG_BLANK : seg_decode(digit);
    end
  end

endmodule

// File: tb/tb_score_counter_bcd.sv
module tb_score_counter_bcd;

  localparam int D = 3;

  logic clk;
  logic reset;
  logic active;
  logic clear;
  logic clear_high;
  logic increment;

  // Wrapping counter with leading-zero blanking
  logic [4*D-1:0] w_score, w_high;
  logic [7*D-1:0] w_disp;
  logic           w_ovf, w_new;
  // Saturating counter
  logic [4*D-1:0] s_score, s_high;
  logic [7*D-1:0] s_disp;
  logic           s_ovf, s_new;
  // Wrapping counter without blanking
  logic [4*D-1:0] n_score, n_high;
  logic [7*D-1:0] n_disp;
  logic           n_ovf, n_new;

  int n_checks = 0;
  int n_fail   = 0;

  score_counter_bcd #(.DIGITS(D), .WRAP(1'b1), .BLANK_LZ(1'b1)) u_wrap (
    .clk(clk), .reset(reset), .active(active), .clear(clear),
    .clear_high(clear_high), .increment(increment),
    .score_bcd(w_score), .display(w_disp), .overflow(w_ovf),
    .high_score(w_high), .new_high(w_new)
  );

  score_counter_bcd #(.DIGITS(D), .WRAP(1'b0), .BLANK_LZ(1'b1)) u_sat (
    .clk(clk), .reset(reset), .active(active), .clear(clear),
    .clear_high(clear_high), .increment(increment),
    .score_bcd(s_score), .display(s_disp), .overflow(s_ovf),
    .high_score(s_high), .new_high(s_new)
  );

  score_counter_bcd #(.DIGITS(D), .WRAP(1'b1), .BLANK_LZ(1'b0)) u_noblank (
    .clk(clk), .reset(reset), .active(active), .clear(clear),
    .clear_high(clear_high), .increment(increment),
    .score_bcd(n_score), .display(n_disp), .overflow(n_ovf),
    .high_score(n_high), .new_high(n_new)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock edge and settle past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hold increment high for n consecutive edges, then drop it for one edge.
  task automatic count_level(input int n);
    increment = 1'b1;
    for (int i = 0; i < n; i++) step();
    increment = 1'b0;
    step();
  endtask

  // n single-cycle increment pulses, each followed by an idle cycle.
  task automatic count_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      increment = 1'b1;
      step();
      increment = 1'b0;
      step();
    end
  endtask

  initial begin
    reset      = 1'b0;
    active     = 1'b0;
    clear      = 1'b0;
    clear_high = 1'b0;
    increment  = 1'b0;

    // Reset state, observed before any clock edge
    #1 reset = 1'b1;
    #1;
    check("rst_score",   w_score, 32'h000);
    check("rst_high",    w_high,  32'h000);
    check("rst_ovf",     w_ovf,   32'd0);
    check("rst_new",     w_new,   32'd0);
    check("rst_disp_lz", w_disp,  {7'h7F, 7'h7F, 7'h40});
    check("rst_disp_nb", n_disp,  {7'h40, 7'h40, 7'h40});
    step();
    step();
    reset = 1'b0;

    // Idle: increment ignored while inactive
    increment = 1'b1;
    step(); step(); step();
    increment = 1'b0;
    check("idle_score", w_score, 32'h000);
    check("idle_ovf",   w_ovf,   32'd0);
    check("idle_disp",  w_disp,  {7'h7F, 7'h7F, 7'h40});

    // Carry chain
    active = 1'b1;
    count_pulses(10);
    check("c10_score",   w_score, 32'h010);
    check("c10_disp",    w_disp,  {7'h7F, 7'h79, 7'h40});
    check("c10_disp_nb", n_disp,  {7'h40, 7'h79, 7'h40});
    check("c10_high",    w_high,  32'h010);
    check("c10_new",     w_new,   32'd1);
    count_pulses(99);
    check("c109_score", w_score, 32'h109);
    check("c109_disp",  w_disp,  {7'h79, 7'h40, 7'h10});

    // Run up to max, then wrap vs saturate
    count_level(890);
    check("max_w_score", w_score, 32'h999);
    check("max_s_score", s_score, 32'h999);
    check("max_w_high",  w_high,  32'h999);
    check("max_ovf",     w_ovf,   32'd0);
    increment = 1'b1;
    step();
    check("wrap_score",   w_score, 32'h000);
    check("wrap_ovf",     w_ovf,   32'd1);
    check("sat_score1",   s_score, 32'h999);
    check("sat_ovf1",     s_ovf,   32'd1);
    step();
    check("wrap_ovf_end", w_ovf,   32'd0);
    check("wrap_score1",  w_score, 32'h001);
    check("sat_ovf2",     s_ovf,   32'd1);
    step();
    check("sat_ovf3",     s_ovf,   32'd1);
    check("sat_score3",   s_score, 32'h999);
    increment = 1'b0;
    step();
    check("sat_ovf_end",  s_ovf,   32'd0);
    check("wrap_keep_hi", w_high,  32'h999);

    // High score: fresh session
    #3 reset = 1'b1;
    step();
    reset = 1'b0;
    count_level(42);
    check("hs42_score", w_score, 32'h042);
    check("hs42_high",  w_high,  32'h042);
    check("hs42_new",   w_new,   32'd1);
    active = 1'b0;
    step();
    check("inact_score", w_score, 32'h000);
    check("inact_new",   w_new,   32'd0);
    check("inact_high",  w_high,  32'h042);
    active = 1'b1;
    count_level(30);
    check("hs30_score", w_score, 32'h030);
    check("hs30_high",  w_high,  32'h042);
    check("hs30_new",   w_new,   32'd0);
    increment = 1'b1;
    for (int i = 0; i < 13; i++) step();
    increment = 1'b0;
    check("hs43_score", w_score, 32'h043);
    check("hs43_lag",   w_high,  32'h042);
    step();
    check("hs43_high",  w_high,  32'h043);
    check("hs43_new",   w_new,   32'd1);
    clear_high = 1'b1;
    step();
    clear_high = 1'b0;
    check("clrh_high",  w_high,  32'h000);
    step();
    check("clrh_recap", w_high,  32'h043);

    // Asynchronous reset mid-count
    count_level(14);
    check("pre_rst_score", w_score, 32'h057);
    check("pre_rst_disp",  w_disp,  {7'h7F, 7'h12, 7'h78});
    #3 reset = 1'b1;
    #1;
    check("arst_score", w_score, 32'h000);
    check("arst_high",  w_high,  32'h000);
    check("arst_new",   w_new,   32'd0);
    check("arst_disp",  w_disp,  {7'h7F, 7'h7F, 7'h40});
    step();
    reset = 1'b0;
    count_level(3);
    check("restart_score", w_score, 32'h003);
    clear     = 1'b1;
    increment = 1'b1;
    step();
    check("clr_wins_score", w_score, 32'h000);
    check("clr_ovf",        w_ovf,   32'd0);
    check("clr_new",        w_new,   32'd0);
    check("clr_keep_high",  w_high,  32'h003);
    clear = 1'b0;
    step();
    increment = 1'b0;
    check("post_clr_score", w_score, 32'h001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
